// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 2-flop synchronizer, start-bit glitch reject and framing check.
// Defining UART_RX_PARITY_EN adds one even-parity bit between the data bits and the stop bit.
module uart_rx #(
    parameter int CLK_PER_BIT = 1250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_parity_err,
    output logic       rx_busy
);
    localparam logic [15:0] BIT_END  = 16'(CLK_PER_BIT - 1);
    localparam logic [15:0] HALF_END = 16'(CLK_PER_BIT / 2 - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
`endif

    state_t      state;
    logic        sync1;
    logic        rx_s;
    logic [15:0] cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;
    logic        tick;

    assign tick    = (cnt == BIT_END);
    assign rx_busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx;
            rx_s  <= sync1;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bad;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_cnt       <= '0;
            shift         <= '0;
            par_bad       <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_parity_err <= 1'b0;
        end else begin
            rx_valid      <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_parity_err <= 1'b0;
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_cnt <= '0;
                    if (!rx_s) state <= START;
                end
                START: begin
                    if (cnt == HALF_END) begin
                        cnt   <= '0;
                        state <= rx_s ? IDLE : DATA;
                    end else cnt <= cnt + 16'd1;
                end
                DATA: begin
                    if (tick) begin
                        cnt     <= '0;
                        shift   <= {rx_s, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end else cnt <= cnt + 16'd1;
                end
                PARITY: begin
                    if (tick) begin
                        cnt     <= '0;
                        par_bad <= rx_s ^ (^shift);
                        state   <= STOP;
                    end else cnt <= cnt + 16'd1;
                end
                STOP: begin
                    if (tick) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            rx_frame_err <= 1'b1;
                            state        <= WAIT_IDLE;
                        end else if (par_bad) begin
                            rx_parity_err <= 1'b1;
                            state         <= IDLE;
                        end else begin
                            rx_data  <= shift;
                            rx_valid <= 1'b1;
                            state    <= IDLE;
                        end
                    end else cnt <= cnt + 16'd1;
                end
                WAIT_IDLE: begin
                    cnt <= '0;
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign rx_parity_err = 1'b0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_cnt      <= '0;
            shift        <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_cnt <= '0;
                    if (!rx_s) state <= START;
                end
                START: begin
                    if (cnt == HALF_END) begin
                        cnt   <= '0;
                        state <= rx_s ? IDLE : DATA;
                    end else cnt <= cnt + 16'd1;
                end
                DATA: begin
                    if (tick) begin
                        cnt     <= '0;
                        shift   <= {rx_s, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= STOP;
                    end else cnt <= cnt + 16'd1;
                end
                STOP: begin
                    if (tick) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            rx_frame_err <= 1'b1;
                            state        <= WAIT_IDLE;
                        end else begin
                            rx_data  <= shift;
                            rx_valid <= 1'b1;
                            state    <= IDLE;
                        end
                    end else cnt <= cnt + 16'd1;
                end
                WAIT_IDLE: begin
                    cnt <= '0;
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL provide parameter CLK_PER_BIT, default 1250, meaning clk cycles per serial bit (9600 baud at 12 MHz); legal range 16..65535.
REQ-002 SHALL provide port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL provide port rx  input  1  asynchronous serial line; idle high; 8N1 frame, LSB first.
REQ-005 SHALL provide port rx_data  output  8  last correctly framed byte; held until the next good frame.
REQ-006 SHALL provide port rx_valid  output  1  one-cycle pulse; rx_data is new.
REQ-007 SHALL provide port rx_frame_err  output  1  one-cycle pulse; stop bit sampled low.
REQ-008 SHALL provide port rx_parity_err  output  1  one-cycle pulse; parity mismatch (see Configuration).
REQ-009 SHALL provide port rx_busy  output  1  high in every state except IDLE.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer; both flops reset to 1; all logic uses the synchronized value rx_s only.
REQ-011 SHALL implement states IDLE, START, DATA, PARITY (macro only), STOP and WAIT_IDLE.
REQ-012 IDLE: on rx_s=0 SHALL enter START with bit counter cleared.
REQ-013 START: SHALL sample rx_s after CLK_PER_BIT/2 cycles (integer divide); sample 0 -> DATA; sample 1 -> IDLE (glitch reject), no output pulse.
REQ-014 DATA: SHALL sample rx_s every CLK_PER_BIT cycles, 8 samples, shifting into bit 7 so the first bit lands in bit 0; after the 8th sample -> PARITY if enabled, else STOP.
REQ-015 STOP: SHALL sample rx_s CLK_PER_BIT cycles after the previous sample.
REQ-016 STOP sample 1, no parity error: SHALL load rx_data and pulse rx_valid in the cycle after the sample, then go to IDLE.
REQ-017 STOP sample 0: SHALL pulse rx_frame_err, leave rx_data unchanged, suppress rx_valid, and enter WAIT_IDLE.
REQ-018 WAIT_IDLE: SHALL stay there until rx_s=1 (line break or stuck-low) and only then enter IDLE.
REQ-019 The cycle counter SHALL be 16 bits and clear on every sample and every state change; no wrap within a bit period.
REQ-020 rx_valid, rx_frame_err and rx_parity_err SHALL never be high for more than one consecutive cycle and SHALL never be high in the same cycle as each other.
REQ-021 A falling edge arriving in the same cycle as the return to IDLE SHALL start a new frame; back-to-back frames with a one-bit stop SHALL be received without loss.
REQ-022 Latency: rx_valid SHALL rise 2 + CLK_PER_BIT/2 + 9*CLK_PER_BIT + 1 cycles after the rx falling edge (2 synchronizer cycles included); with parity enabled, add CLK_PER_BIT.

Reset
REQ-023 While rst_n=0 at a clk edge: state=IDLE, counters=0, rx_data=8'h00, rx_valid=0, rx_frame_err=0, rx_parity_err=0, rx_busy=0, synchronizer=1.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no output pulse; reception resumes on the first falling edge after release.

Configuration
REQ-025 Macro UART_RX_PARITY_EN, when defined, SHALL add state PARITY: one even-parity bit sampled CLK_PER_BIT after the 8th data bit; a mismatch with a good stop bit SHALL pulse rx_parity_err instead of rx_valid, with rx_data unchanged.
REQ-026 When UART_RX_PARITY_EN is defined, a mismatch together with a bad stop bit SHALL report rx_frame_err only.
REQ-027 Without UART_RX_PARITY_EN, the frame SHALL be 8N1, the PARITY state SHALL not exist, and rx_parity_err SHALL be tied to 0.

Verification
REQ-028 CLK_PER_BIT=16, drive frame 8'hA5, stop=1 -> exactly one rx_valid pulse, rx_data=8'hA5, at the latency given in REQ-022.
REQ-029 Two back-to-back frames 8'h00 then 8'hFF, no idle gap -> two rx_valid pulses, rx_data 8'h00 then 8'hFF.
REQ-030 Low glitch on rx of 4 cycles at CLK_PER_BIT=16 -> no pulse on any output; rx_busy returns to 0.
REQ-031 Frame 8'h3C with stop=0, rx held low for 40 cycles -> rx_frame_err pulses once; rx_data keeps its prior value; no new frame starts until rx returns high.
REQ-032 rst_n low for 1 cycle in the middle of the DATA state -> all outputs at reset values; a following 8'h5A frame is received correctly.
REQ-033 UART_RX_PARITY_EN defined: 8'h07 with parity 1 -> rx_valid; same byte with parity 0 -> rx_parity_err, no rx_valid.
